// File: rtl/ctrl_hazard_pipe.sv
// Control-side pipeline for the 5-stage core: carries decoded control through ID/EX, EX/MEM and MEM/WB,
// raises load-use stalls back to the decoder and redirects the PC on branch/jump resolved in MEM.
module ctrl_hazard_pipe #(
  parameter int CNT_W = 16,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       id_ctrl,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             ex_zero,
  output logic             en_reg,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [1:0]       pc_src,
  output logic [3:0]       ex_ctrl,
  output logic [RA_W-1:0]  ex_rt,
  output logic [3:0]       mem_ctrl,
  output logic [RA_W-1:0]  mem_dst,
  output logic [1:0]       wb_ctrl,
  output logic [RA_W-1:0]  wb_dst,
  output logic [CNT_W-1:0] stall_cnt
);

  // bundle layout: [9] RegDst [8] ALUSrc [7:6] ALUOp [5] MemRead [4] MemWrite
  //                [3] Branch [2] Jump [1] MemtoReg [0] RegWrite
  logic [9:0]      idex_ctrl;
  logic [RA_W-1:0] idex_rt;
  logic [RA_W-1:0] idex_rd;
  logic [5:0]      exmem_ctrl;
  logic            mem_zero;

  logic [9:0]      id_sane;
  logic            take;
  logic            hazard;
  logic            stall;

  always_comb begin
    id_sane = id_ctrl;
    if (!id_ctrl[0]) begin
      id_sane[9] = 1'b0;
      id_sane[1] = 1'b0;
    end
  end

  always_comb begin
    take   = exmem_ctrl[2] | (exmem_ctrl[3] & mem_zero);
    hazard = idex_ctrl[5] & (idex_rt != '0) & ((idex_rt == id_rs) | (idex_rt == id_rt));
    stall  = hazard & ~take;

    en_reg     = ~(take | stall);
    pc_write   = ~stall;
    ifid_write = ~stall;
    ifid_flush = take;
    if (exmem_ctrl[2])
      pc_src = 2'b10;
    else if (take)
      pc_src = 2'b01;
    else
      pc_src = 2'b00;

    // stage registers may still hold a taken branch or a load until the reset edge lands
    if (rst) begin
      en_reg     = 1'b0;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      pc_src     = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ctrl  <= '0;
      idex_rt    <= '0;
      idex_rd    <= '0;
      exmem_ctrl <= '0;
      mem_zero   <= 1'b0;
      mem_dst    <= '0;
      wb_ctrl    <= '0;
      wb_dst     <= '0;
      stall_cnt  <= '0;
    end else begin
      if (take || stall) begin
        idex_ctrl <= '0;
        idex_rt   <= '0;
        idex_rd   <= '0;
      end else begin
        idex_ctrl <= id_sane;
        idex_rt   <= id_rt;
        idex_rd   <= id_rd;
      end

      if (take) begin
        exmem_ctrl <= '0;
        mem_zero   <= 1'b0;
        mem_dst    <= '0;
      end else begin
        exmem_ctrl <= idex_ctrl[5:0];
        mem_zero   <= ex_zero;
        mem_dst    <= idex_ctrl[9] ? idex_rd : idex_rt;
      end

      // the branch/jump in MEM still retires while younger stages are squashed
      wb_ctrl <= exmem_ctrl[1:0];
      wb_dst  <= mem_dst;

      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign ex_ctrl  = idex_ctrl[9:6];
  assign ex_rt    = idex_rt;
  assign mem_ctrl = exmem_ctrl[5:2];

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Scoreboard bench for ctrl_hazard_pipe: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_ctrl_hazard_pipe;

  localparam int CNT_W = 4;
  localparam int RA_W  = 5;

  localparam logic [9:0] RTYPE = 10'b1010000001;
  localparam logic [9:0] LW    = 10'b0100100011;
  localparam logic [9:0] BEQ   = 10'b0001001000;
  localparam logic [9:0] JMP   = 10'b0000001100;
  localparam logic [9:0] SWX   = 10'b1000010010;

  localparam int S_EN = 0, S_PCW = 1, S_IFW = 2, S_FL = 3, S_PCSRC = 4, S_EXC = 5,
                 S_EXRT = 6, S_MEMC = 7, S_MEMD = 8, S_WBC = 9, S_WBD = 10, S_CNT = 11;

  logic             clk;
  logic             rst;
  logic [9:0]       id_ctrl;
  logic [RA_W-1:0]  id_rs, id_rt, id_rd;
  logic             ex_zero;
  logic             en_reg, pc_write, ifid_write, ifid_flush;
  logic [1:0]       pc_src;
  logic [3:0]       ex_ctrl;
  logic [RA_W-1:0]  ex_rt;
  logic [3:0]       mem_ctrl;
  logic [RA_W-1:0]  mem_dst;
  logic [1:0]       wb_ctrl;
  logic [RA_W-1:0]  wb_dst;
  logic [CNT_W-1:0] stall_cnt;

  ctrl_hazard_pipe #(.CNT_W(CNT_W), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_zero(ex_zero), .en_reg(en_reg), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .pc_src(pc_src), .ex_ctrl(ex_ctrl), .ex_rt(ex_rt),
    .mem_ctrl(mem_ctrl), .mem_dst(mem_dst), .wb_ctrl(wb_ctrl), .wb_dst(wb_dst),
    .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    int          cyc;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      S_EN:    obs = 16'(en_reg);
      S_PCW:   obs = 16'(pc_write);
      S_IFW:   obs = 16'(ifid_write);
      S_FL:    obs = 16'(ifid_flush);
      S_PCSRC: obs = 16'(pc_src);
      S_EXC:   obs = 16'(ex_ctrl);
      S_EXRT:  obs = 16'(ex_rt);
      S_MEMC:  obs = 16'(mem_ctrl);
      S_MEMD:  obs = 16'(mem_dst);
      S_WBC:   obs = 16'(wb_ctrl);
      S_WBD:   obs = 16'(wb_dst);
      default: obs = 16'(stall_cnt);
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_EN:    sel_name = "en_reg";
      S_PCW:   sel_name = "pc_write";
      S_IFW:   sel_name = "ifid_write";
      S_FL:    sel_name = "ifid_flush";
      S_PCSRC: sel_name = "pc_src";
      S_EXC:   sel_name = "ex_ctrl";
      S_EXRT:  sel_name = "ex_rt";
      S_MEMC:  sel_name = "mem_ctrl";
      S_MEMD:  sel_name = "mem_dst";
      S_WBC:   sel_name = "wb_ctrl";
      S_WBD:   sel_name = "wb_dst";
      default: sel_name = "stall_cnt";
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e_m = q.pop_front();
      checks++;
      if (e_m.cyc != cyc) begin
        errors++;
        $display("FAIL %s stale expectation for cyc=%0d seen at cyc=%0d", sel_name(e_m.sel), e_m.cyc, cyc);
      end else if (obs(e_m.sel) !== e_m.val) begin
        errors++;
        $display("FAIL %s cyc=%0d actual=%0h required=%0h", sel_name(e_m.sel), cyc, obs(e_m.sel), e_m.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] c, input int rs, input int rt, input int rd);
    id_ctrl = c;
    id_rs   = RA_W'(rs);
    id_rt   = RA_W'(rt);
    id_rd   = RA_W'(rd);
  endtask

  task automatic chk(input int sel, input int v);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.val = 16'(v);
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    ex_zero = 1'b0;
    drive(10'b0, 0, 0, 0);
    tick();
    chk(S_EN, 0); chk(S_PCW, 1); chk(S_IFW, 1); chk(S_FL, 0); chk(S_PCSRC, 0);
    chk(S_EXC, 0); chk(S_MEMC, 0); chk(S_WBC, 0); chk(S_CNT, 0);
    tick();
    rst = 1'b0;

    // R-type latency through all three stages
    drive(RTYPE, 1, 2, 5); chk(S_EN, 1);
    tick(); drive(10'b0, 0, 0, 0); chk(S_EXC, 4'b1010); chk(S_EXRT, 2);
    tick(); chk(S_MEMC, 4'b0000); chk(S_MEMD, 5);
    tick(); chk(S_WBC, 2'b01); chk(S_WBD, 5);

    // RegWrite=0 clears RegDst and MemtoReg on the way in
    drive(SWX, 0, 3, 9);
    tick(); drive(10'b0, 0, 0, 0); chk(S_EXC, 4'b0000);
    tick(); chk(S_MEMC, 4'b0100); chk(S_MEMD, 3);
    tick(); chk(S_WBC, 2'b00); chk(S_WBD, 3);

    // load-use on rs
    drive(LW, 9, 8, 0);
    tick(); drive(RTYPE, 8, 3, 10);
    chk(S_PCW, 0); chk(S_IFW, 0); chk(S_EN, 0); chk(S_EXRT, 8); chk(S_FL, 0);
    tick(); chk(S_EXC, 0); chk(S_CNT, 1); chk(S_EN, 1); chk(S_PCW, 1); chk(S_MEMC, 4'b1000); chk(S_MEMD, 8);
    tick(); drive(10'b0, 0, 0, 0); chk(S_EXC, 4'b1010); chk(S_WBC, 2'b11); chk(S_WBD, 8); chk(S_CNT, 1);
    tick();

    // load-use on rt
    drive(LW, 0, 7, 0);
    tick(); drive(RTYPE, 1, 7, 11); chk(S_EN, 0); chk(S_PCW, 0);
    tick(); chk(S_CNT, 2); chk(S_EN, 1);
    tick(); drive(10'b0, 0, 0, 0);
    tick();

    // load followed by an unrelated consumer
    drive(LW, 0, 7, 0);
    tick(); drive(RTYPE, 6, 5, 12); chk(S_EN, 1); chk(S_PCW, 1);
    tick(); drive(10'b0, 0, 0, 0); chk(S_CNT, 2);

    // load into $zero never stalls
    drive(LW, 0, 0, 0);
    tick(); drive(RTYPE, 0, 0, 4); chk(S_EN, 1); chk(S_IFW, 1);
    tick(); drive(10'b0, 0, 0, 0); chk(S_CNT, 2);
    tick();

    // taken branch
    drive(BEQ, 1, 2, 0);
    tick(); ex_zero = 1'b1; drive(RTYPE, 3, 4, 6); chk(S_PCSRC, 0);
    tick(); ex_zero = 1'b0; drive(RTYPE, 3, 4, 7);
    chk(S_PCSRC, 2'b01); chk(S_FL, 1); chk(S_EN, 0); chk(S_PCW, 1); chk(S_IFW, 1);
    chk(S_EXC, 4'b1010); chk(S_MEMC, 4'b0010);
    tick(); drive(10'b0, 0, 0, 0);
    chk(S_EXC, 0); chk(S_MEMC, 0); chk(S_WBC, 0); chk(S_PCSRC, 0); chk(S_FL, 0);
    tick();

    // not-taken branch
    drive(BEQ, 1, 2, 0);
    tick(); ex_zero = 1'b0; drive(10'b0, 0, 0, 0);
    tick(); chk(S_PCSRC, 0); chk(S_FL, 0); chk(S_EN, 1); chk(S_MEMC, 4'b0010);
    tick();

    // jump in MEM overrides a load-use hazard in ID/EX
    drive(JMP, 0, 0, 0);
    tick(); drive(LW, 0, 8, 0);
    tick(); drive(RTYPE, 8, 0, 13);
    chk(S_PCSRC, 2'b10); chk(S_FL, 1); chk(S_EN, 0); chk(S_PCW, 1); chk(S_IFW, 1);
    chk(S_EXRT, 8); chk(S_MEMC, 4'b0011);
    tick(); drive(10'b0, 0, 0, 0);
    chk(S_CNT, 2); chk(S_EXC, 0); chk(S_MEMC, 0); chk(S_WBC, 0);
    tick();

    // 15 more stalls push a 4-bit counter from 2 past its ceiling
    drive(LW, 8, 8, 0);
    tick(); chk(S_EN, 0);
    repeat (29) tick();
    drive(10'b0, 0, 0, 0);
    tick();
    tick(); chk(S_CNT, 15); chk(S_EN, 1);

    // reset with a load in EX and a taken branch in MEM
    drive(BEQ, 1, 2, 0);
    tick(); ex_zero = 1'b1; drive(LW, 0, 8, 0);
    tick(); ex_zero = 1'b0; rst = 1'b1; drive(RTYPE, 8, 0, 1);
    chk(S_PCSRC, 0); chk(S_FL, 0); chk(S_EN, 0); chk(S_PCW, 1); chk(S_IFW, 1);
    chk(S_MEMC, 4'b0010); chk(S_EXC, 4'b0100);
    tick(); rst = 1'b0; drive(10'b0, 0, 0, 0);
    chk(S_EXC, 0); chk(S_MEMC, 0); chk(S_WBC, 0); chk(S_CNT, 0); chk(S_PCSRC, 0); chk(S_EN, 1);
    tick();
    tick();

    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL scoreboard %0d expectations never compared", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
